// File: rtl/mul_arbiter_if.sv
// Bundle of request, multiplier and response handshakes around mul_arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface mul_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_signed;

    logic                 mul_valid_o;
    logic                 mul_ready_i;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic                 mul_signed;

    logic                 mul_valid_i;
    logic                 mul_ready_o;
    logic [63:0]          mul_result;

    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [63:0]          rsp_data;

    logic                 busy;
    logic                 err;

    modport slave (
        input  req_valid, req_a, req_b, req_signed,
        input  mul_ready_i, mul_valid_i, mul_result, rsp_ready,
        output req_ready, mul_valid_o, mul_a, mul_b, mul_signed,
        output mul_ready_o, rsp_valid, rsp_data, busy, err
    );

    modport master (
        output req_valid, req_a, req_b, req_signed,
        output mul_ready_i, mul_valid_i, mul_result, rsp_ready,
        input  req_ready, mul_valid_o, mul_a, mul_b, mul_signed,
        input  mul_ready_o, rsp_valid, rsp_data, busy, err
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters;
// a tag FIFO remembers who issued each operation so results return in order.
module mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    mul_arbiter_if.slave  bus
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] tag_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          err_q;

    logic [31:0]   a_arr [NREQ];
    logic [31:0]   b_arr [NREQ];

    logic          any_valid;
    logic [TW-1:0] grant_idx;
    logic [TW-1:0] next_rr;
    logic [TW-1:0] head;
    logic          full;
    logic          empty;
    logic          issue;
    logic          pop;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[32*gi +: 32];
            assign b_arr[gi] = bus.req_b[32*gi +: 32];
        end
    endgenerate

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        int            cand;
        logic [TW-1:0] cand_idx;
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NREQ;
            cand_idx = TW'(cand);
            if (!any_valid && bus.req_valid[cand_idx]) begin
                any_valid = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign next_rr = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign issue   = any_valid && bus.mul_ready_i && !full;
    assign head    = tag_mem[rd_ptr];
    assign pop     = bus.mul_valid_i && !empty && bus.rsp_ready[head];

    always_comb begin
        bus.req_ready   = '0;
        bus.mul_valid_o = issue;
        bus.mul_a       = '0;
        bus.mul_b       = '0;
        bus.mul_signed  = 1'b0;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.mul_a                = a_arr[grant_idx];
            bus.mul_b                = b_arr[grant_idx];
            bus.mul_signed           = bus.req_signed[grant_idx];
        end
    end

    // With nothing outstanding every beat is accepted (and flagged as an error).
    always_comb begin
        bus.rsp_valid   = '0;
        bus.mul_ready_o = 1'b1;
        if (!empty) begin
            bus.mul_ready_o = bus.rsp_ready[head];
            if (bus.mul_valid_i) begin
                bus.rsp_valid[head] = 1'b1;
            end
        end
    end

    assign bus.rsp_data = bus.mul_result;
    assign bus.busy     = !empty;
    assign bus.err      = err_q;

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + PW'(1);
                rr_ptr <= next_rr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (bus.mul_valid_i && empty) begin
                err_q <= 1'b1;
            end
            case ({issue, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: a queue-based model is checked every cycle,
// and literal expectations pin the arbitration, ordering and reset scenarios.
module tb_mul_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mul_arbiter_if #(.NREQ(4)) bus ();

    mul_arbiter #(.NREQ(4), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: tags outstanding in issue order, round-robin start, sticky error.
    int mq[$];
    int m_rr;
    bit m_err;
    bit m_live;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelWinner();
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_rr + k) % 4;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit modelIssue();
        return (modelWinner() >= 0) && bus.mul_ready_i && (mq.size() < 8);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_rr   = 0;
            m_err  = 0;
            m_live = 1;
        end else if (m_live) begin
            int w;
            bit iss;
            w   = modelWinner();
            iss = modelIssue();
            if (bus.mul_valid_i) begin
                if (mq.size() == 0) m_err = 1;
                else if (bus.rsp_ready[mq[0]]) void'(mq.pop_front());
            end
            if (iss) begin
                mq.push_back(w);
                m_rr = (w + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            int         w;
            bit         iss;
            logic [3:0] exp_ready;
            logic [3:0] exp_rsp;
            logic [31:0] exp_a;
            logic [31:0] exp_b;
            logic        exp_s;
            w         = modelWinner();
            iss       = modelIssue();
            exp_ready = 4'b0;
            exp_a     = 32'h0;
            exp_b     = 32'h0;
            exp_s     = 1'b0;
            if (iss) begin
                exp_ready[w] = 1'b1;
                exp_a        = bus.req_a[32*w +: 32];
                exp_b        = bus.req_b[32*w +: 32];
                exp_s        = bus.req_signed[w];
            end
            exp_rsp = 4'b0;
            if (mq.size() > 0 && bus.mul_valid_i) exp_rsp[mq[0]] = 1'b1;
            checkOutput("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
            checkOutput("m_mul_valid_o", 64'(bus.mul_valid_o), 64'(iss));
            checkOutput("m_mul_a", 64'(bus.mul_a), 64'(exp_a));
            checkOutput("m_mul_b", 64'(bus.mul_b), 64'(exp_b));
            checkOutput("m_mul_signed", 64'(bus.mul_signed), 64'(exp_s));
            checkOutput("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
            checkOutput("m_rsp_data", bus.rsp_data, bus.mul_result);
            checkOutput("m_busy", 64'(bus.busy), 64'(mq.size() != 0));
            checkOutput("m_err", 64'(bus.err), 64'(m_err));
            if (mq.size() == 0)
                checkOutput("m_mul_ready_o_empty", 64'(bus.mul_ready_o), 64'h1);
            else if (bus.mul_valid_i)
                checkOutput("m_mul_ready_o", 64'(bus.mul_ready_o), 64'(bus.rsp_ready[mq[0]]));
        end
    end

    task automatic applyStimulus(input logic rstn, input logic [3:0] valid, input logic rdy_i,
                                 input logic mv_i, input logic [3:0] rsp_rdy, input logic [63:0] result);
        @(posedge clk);
        #1;
        rst_n           = rstn;
        bus.req_valid   = valid;
        bus.mul_ready_i = rdy_i;
        bus.mul_valid_i = mv_i;
        bus.rsp_ready   = rsp_rdy;
        bus.mul_result  = result;
        #2;
    endtask

    initial begin
        logic [3:0] rr_seq [8];
        total           = 0;
        bad             = 0;
        m_live          = 0;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.mul_ready_i = 1'b1;
        bus.mul_valid_i = 1'b0;
        bus.rsp_ready   = '0;
        bus.mul_result  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[32*i +: 32] = 32'h1111_1111 * (i + 1);
            bus.req_b[32*i +: 32] = 32'h0000_0010 + i;
            bus.req_signed[i]     = i[0];
        end

        // Reset state
        applyStimulus(0, 4'h0, 1, 0, 4'h0, 64'h0);
        applyStimulus(0, 4'h0, 1, 0, 4'h0, 64'h0);
        checkOutput("rst_busy", 64'(bus.busy), 64'h0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("rst_mul_ready_o", 64'(bus.mul_ready_o), 64'h1);
        checkOutput("rst_mul_valid_o", 64'(bus.mul_valid_o), 64'h0);
        checkOutput("rst_err", 64'(bus.err), 64'h0);

        // Requesters 0 and 2 alternate; requester 1 idle
        rr_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'b0101, 1, 0, 4'h0, 64'h0);
            checkOutput($sformatf("alt_grant%0d", i), 64'(bus.req_ready), 64'(rr_seq[i]));
        end
        checkOutput("alt_mul_a", 64'(bus.mul_a), 64'h3333_3333);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'h0, 1, 1, 4'hF, 64'h100 + 64'(i));
            checkOutput($sformatf("alt_rsp%0d", i), 64'(bus.rsp_valid), 64'(rr_seq[i]));
        end
        applyStimulus(1, 4'h0, 1, 0, 4'h0, 64'h0);
        checkOutput("alt_idle_busy", 64'(bus.busy), 64'h0);

        // All requesters valid: fill to DEPTH, then the full/accept corner
        applyStimulus(0, 4'h0, 1, 0, 4'h0, 64'h0);
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 4'hF, 1, 0, 4'h0, 64'h0);
            checkOutput($sformatf("all_grant%0d", i), 64'(bus.req_ready), 64'(rr_seq[i]));
        end
        applyStimulus(1, 4'hF, 1, 0, 4'h0, 64'h0);
        checkOutput("full_no_issue", 64'(bus.mul_valid_o), 64'h0);
        checkOutput("full_busy", 64'(bus.busy), 64'h1);
        applyStimulus(1, 4'hF, 1, 1, 4'hF, 64'h55);
        checkOutput("full_accept_no_issue", 64'(bus.mul_valid_o), 64'h0);
        checkOutput("full_accept_rsp", 64'(bus.rsp_valid), 64'b0001);
        applyStimulus(1, 4'hF, 1, 0, 4'h0, 64'h0);
        checkOutput("after_accept_issue", 64'(bus.mul_valid_o), 64'h1);
        checkOutput("after_accept_grant", 64'(bus.req_ready), 64'b0001);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 4'h0, 1, 1, 4'hF, 64'h200 + 64'(i));
            if (i == 0) checkOutput("drain_rsp0", 64'(bus.rsp_valid), 64'b0010);
            if (i == 1) checkOutput("drain_rsp1", 64'(bus.rsp_valid), 64'b0100);
        end

        // Signed corner from requester 3
        bus.req_a[96 +: 32] = 32'hFFFF_FFFF;
        bus.req_b[96 +: 32] = 32'h0000_0002;
        applyStimulus(1, 4'b1000, 1, 0, 4'h0, 64'h0);
        checkOutput("r3_grant", 64'(bus.req_ready), 64'b1000);
        checkOutput("r3_mul_a", 64'(bus.mul_a), 64'hFFFF_FFFF);
        checkOutput("r3_mul_b", 64'(bus.mul_b), 64'h2);
        checkOutput("r3_mul_signed", 64'(bus.mul_signed), 64'h1);
        applyStimulus(1, 4'h0, 1, 1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("r3_rsp_valid", 64'(bus.rsp_valid), 64'b1000);
        checkOutput("r3_rsp_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);

        // Back-pressure on requester 1 holds the result; order 1 then 2
        applyStimulus(1, 4'b0010, 1, 0, 4'h0, 64'h0);
        checkOutput("bp_grant1", 64'(bus.req_ready), 64'b0010);
        applyStimulus(1, 4'b0100, 1, 0, 4'h0, 64'h0);
        checkOutput("bp_grant2", 64'(bus.req_ready), 64'b0100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'h0, 1, 1, 4'b1101, 64'h11);
            checkOutput($sformatf("bp_hold_rsp%0d", i), 64'(bus.rsp_valid), 64'b0010);
            checkOutput($sformatf("bp_hold_rdy%0d", i), 64'(bus.mul_ready_o), 64'h0);
        end
        applyStimulus(1, 4'h0, 1, 1, 4'hF, 64'h11);
        checkOutput("bp_pop1", 64'(bus.rsp_valid), 64'b0010);
        applyStimulus(1, 4'h0, 1, 1, 4'hF, 64'h22);
        checkOutput("bp_pop2", 64'(bus.rsp_valid), 64'b0100);
        applyStimulus(1, 4'h0, 1, 0, 4'h0, 64'h0);
        checkOutput("bp_empty_busy", 64'(bus.busy), 64'h0);

        // Reset with three in flight, then a stray result
        for (int i = 0; i < 3; i++) applyStimulus(1, 4'hF, 1, 0, 4'h0, 64'h0);
        applyStimulus(0, 4'h0, 1, 0, 4'h0, 64'h0);
        applyStimulus(1, 4'h0, 1, 1, 4'hF, 64'h77);
        checkOutput("stray_busy", 64'(bus.busy), 64'h0);
        checkOutput("stray_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("stray_mul_ready_o", 64'(bus.mul_ready_o), 64'h1);
        applyStimulus(1, 4'h0, 1, 0, 4'h0, 64'h0);
        checkOutput("stray_err", 64'(bus.err), 64'h1);
        applyStimulus(1, 4'h0, 1, 0, 4'h0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
